// File: rtl/mem_stage_ext_pkg.sv
// Shared constants and helpers for the MEM stage: access sizes, FSM encodings,
// alignment check and load/store lane formatting.
package mem_stage_pkg;

  typedef logic [1:0] size_t;

  localparam size_t SZ_BYTE = 2'b00;
  localparam size_t SZ_HALF = 2'b01;
  localparam size_t SZ_WORD = 2'b10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic is_misaligned(input logic [1:0] lo, input size_t size);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lo[0];
      default: return lo != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] store_lanes(input logic [1:0] lo, input size_t size);
    case (size)
      SZ_BYTE: return 4'b0001 << lo;
      SZ_HALF: return lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate the right-aligned store data so every enabled lane sees it.
  function automatic logic [31:0] store_align(input logic [31:0] data, input size_t size);
    case (size)
      SZ_BYTE: return {4{data[7:0]}};
      SZ_HALF: return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lo,
                                              input size_t size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lo, 3'b000} +: 8];
    h = lo[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: return uns ? {24'b0, b} : {{24{b[7]}}, b};
      SZ_HALF: return uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_ext_if.sv
// EX/MEM inputs and MEM/WB outputs of the MEM stage, bundled as one bus.
interface mem_stage_ext_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int REG_W  = 5,
  parameter int WB_W   = 2
);
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] write_data;
  logic              m_ctlout;
  logic              zero;
  logic [REG_W-1:0]  write_reg_in;
  logic [WB_W-1:0]   control_wb_in;
  logic              memwrite;
  logic              memread;
  logic [1:0]        mem_size;
  logic              mem_unsigned;
  logic [DATA_W-1:0] read_data;
  logic [DATA_W-1:0] mem_ALU_result;
  logic [WB_W-1:0]   mem_control_wb;
  logic [REG_W-1:0]  mem_write_reg;
  logic              misalign;
  logic              PCSrc;
  logic              stall;

  modport master (
    output address, write_data, m_ctlout, zero, write_reg_in, control_wb_in,
           memwrite, memread, mem_size, mem_unsigned,
    input  read_data, mem_ALU_result, mem_control_wb, mem_write_reg, misalign,
           PCSrc, stall
  );

  modport slave (
    input  address, write_data, m_ctlout, zero, write_reg_in, control_wb_in,
           memwrite, memread, mem_size, mem_unsigned,
    output read_data, mem_ALU_result, mem_control_wb, mem_write_reg, misalign,
           PCSrc, stall
  );
endinterface

// File: rtl/mem_stage_ext_dmem_byte_ram.sv
// DEPTH x 32 data memory built from four byte lanes; byte-enable write,
// combinational read, contents never reset.
module dmem_byte_ram #(
  parameter int DEPTH = 256,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] idx,
  input  logic [3:0]       be,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];

      always_ff @(posedge clk) begin
        if (be[gi]) begin
          lane_mem[idx] <= wdata[gi*8 +: 8];
        end
      end

      assign rdata[gi*8 +: 8] = lane_mem[idx];
    end
  endgenerate
endmodule

// File: rtl/mem_stage_ext.sv
// Pipeline MEM stage: sized loads/stores with wait-state stall, misalignment
// squash, PCSrc and the MEM/WB latch.
module mem_stage_ext
  import mem_stage_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 256,
  parameter int REG_W       = 5,
  parameter int WB_W        = 2,
  parameter int WAIT_STATES = 0
) (
  input logic            clk,
  input logic            reset,
  mem_stage_ext_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [2:0] WAIT_LOAD = 3'(WAIT_STATES - 1);

  logic [ADDR_W-1:0] addr;
  logic [IDX_W-1:0]  word_idx;
  logic              mis_acc;
  logic              access;
  logic              store_req;
  logic              load_req;
  logic              stall_c;
  logic [3:0]        be;
  logic [31:0]       ram_rdata;

  logic [1:0]        state_reg, state_next;
  logic [2:0]        cnt_reg, cnt_next;

  logic [DATA_W-1:0] read_data_reg;
  logic [DATA_W-1:0] alu_result_reg;
  logic [WB_W-1:0]   control_wb_reg;
  logic [REG_W-1:0]  write_reg_reg;
  logic              misalign_reg;

  assign addr      = bus.address;
  assign word_idx  = addr[IDX_W+1:2];
  assign mis_acc   = (bus.memread | bus.memwrite) & is_misaligned(addr[1:0], bus.mem_size);
  assign access    = (bus.memread | bus.memwrite) & ~mis_acc;
  assign store_req = bus.memwrite & ~mis_acc;
  assign load_req  = bus.memread & ~bus.memwrite & ~mis_acc;

  // cnt_reg holds the WAIT cycles still to come, including the current one.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    stall_c    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (access && WAIT_STATES > 0) begin
          stall_c    = 1'b1;
          cnt_next   = WAIT_LOAD;
          state_next = (WAIT_STATES == 1) ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        stall_c  = 1'b1;
        cnt_next = cnt_reg - 3'd1;
        if (cnt_reg <= 3'd1) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign be = (store_req && !stall_c) ? store_lanes(addr[1:0], bus.mem_size) : 4'b0000;

  dmem_byte_ram #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk   (clk),
    .idx   (word_idx),
    .be    (be),
    .wdata (store_align(bus.write_data, bus.mem_size)),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= 3'd0;
      read_data_reg  <= '0;
      alu_result_reg <= '0;
      control_wb_reg <= '0;
      write_reg_reg  <= '0;
      misalign_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (!stall_c) begin
        read_data_reg  <= load_req ? DATA_W'(load_extend(ram_rdata, addr[1:0], bus.mem_size,
                                                         bus.mem_unsigned))
                                   : '0;
        alu_result_reg <= DATA_W'(addr);
        control_wb_reg <= mis_acc ? '0 : bus.control_wb_in;
        write_reg_reg  <= bus.write_reg_in;
        misalign_reg   <= mis_acc;
      end
    end
  end

  assign bus.read_data      = read_data_reg;
  assign bus.mem_ALU_result = alu_result_reg;
  assign bus.mem_control_wb = control_wb_reg;
  assign bus.mem_write_reg  = write_reg_reg;
  assign bus.misalign       = misalign_reg;
  assign bus.PCSrc          = bus.m_ctlout & bus.zero;
  assign bus.stall          = stall_c;

endmodule

// File: tb/tb_mem_stage_ext.sv
// Drives identical instruction streams into a zero-wait and a three-wait MEM
// stage and compares both against a byte-array reference model.
module tb_mem_stage_ext;
  localparam int DEPTH = 256;
  localparam int NB    = DEPTH * 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_stage_ext_if #(.DATA_W(32), .ADDR_W(32), .REG_W(5), .WB_W(2)) b0 ();
  mem_stage_ext_if #(.DATA_W(32), .ADDR_W(32), .REG_W(5), .WB_W(2)) b3 ();

  mem_stage_ext #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .REG_W(5), .WB_W(2),
                  .WAIT_STATES(0)) dut0 (.clk(clk), .reset(rst_n), .bus(b0.slave));
  mem_stage_ext #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .REG_W(5), .WB_W(2),
                  .WAIT_STATES(3)) dut3 (.clk(clk), .reset(rst_n), .bus(b3.slave));

  int total = 0;
  int bad   = 0;
  logic [7:0] m0 [NB];
  logic [7:0] m3 [NB];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [7:0] mem_rd(input int which, input int i);
    return (which == 0) ? m0[i] : m3[i];
  endfunction

  function automatic void mem_wr(input int which, input int i, input logic [7:0] v);
    if (which == 0) m0[i] = v;
    else m3[i] = v;
  endfunction

  function automatic logic ref_mis(input logic rd, input logic wr, input logic [1:0] sz,
                                   input logic [31:0] a);
    return (rd | wr) && ((a % 32'(nbytes(sz))) != 0);
  endfunction

  function automatic logic [31:0] ref_load(input int which, input logic [1:0] sz,
                                           input logic uns, input logic [31:0] a);
    int n, base;
    longint v;
    n = nbytes(sz);
    base = int'(a % 32'(NB));
    v = 0;
    for (int i = 0; i < n; i++) v = v + (longint'(mem_rd(which, base + i)) << (8 * i));
    if (!uns && ((v >> (8 * n - 1)) & 1) == 1) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  function automatic void ref_store(input int which, input logic [1:0] sz,
                                    input logic [31:0] a, input logic [31:0] wd);
    int n, base;
    n = nbytes(sz);
    base = int'(a % 32'(NB));
    for (int i = 0; i < n; i++) mem_wr(which, base + i, 8'(wd >> (8 * i)));
  endfunction

  task automatic drive(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd, input logic [4:0] wreg,
                       input logic [1:0] wb, input logic mc, input logic z);
    b0.memread = rd;       b3.memread = rd;
    b0.memwrite = wr;      b3.memwrite = wr;
    b0.mem_size = sz;      b3.mem_size = sz;
    b0.mem_unsigned = uns; b3.mem_unsigned = uns;
    b0.address = a;        b3.address = a;
    b0.write_data = wd;    b3.write_data = wd;
    b0.write_reg_in = wreg; b3.write_reg_in = wreg;
    b0.control_wb_in = wb; b3.control_wb_in = wb;
    b0.m_ctlout = mc;      b3.m_ctlout = mc;
    b0.zero = z;           b3.zero = z;
  endtask

  task automatic check_outs(input int which, input logic [31:0] e_rd, input logic [31:0] a,
                            input logic [4:0] wreg, input logic [1:0] e_wb, input logic mis);
    string p;
    p = (which == 0) ? "w0" : "w3";
    if (which == 0) begin
      chk({p, ".read_data"}, b0.read_data, e_rd);
      chk({p, ".alu_result"}, b0.mem_ALU_result, a);
      chk({p, ".control_wb"}, 32'(b0.mem_control_wb), 32'(e_wb));
      chk({p, ".write_reg"}, 32'(b0.mem_write_reg), 32'(wreg));
      chk({p, ".misalign"}, 32'(b0.misalign), 32'(mis));
    end else begin
      chk({p, ".read_data"}, b3.read_data, e_rd);
      chk({p, ".alu_result"}, b3.mem_ALU_result, a);
      chk({p, ".control_wb"}, 32'(b3.mem_control_wb), 32'(e_wb));
      chk({p, ".write_reg"}, 32'(b3.mem_write_reg), 32'(wreg));
      chk({p, ".misalign"}, 32'(b3.misalign), 32'(mis));
    end
  endtask

  // Called just after a falling edge; returns just after the falling edge that
  // follows the slower instance's completing rising edge.
  task automatic op(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                    input logic [31:0] a, input logic [31:0] wd, input logic [4:0] wreg,
                    input logic [1:0] wb, input logic mc, input logic z);
    logic mis, acc, ld;
    logic [31:0] e0, e3;
    logic [1:0] e_wb;
    int ns;
    bit w0_done;
    drive(rd, wr, sz, uns, a, wd, wreg, wb, mc, z);
    mis  = ref_mis(rd, wr, sz, a);
    acc  = (rd | wr) && !mis;
    ld   = rd && !wr && !mis;
    e0   = ld ? ref_load(0, sz, uns, a) : 32'h0;
    e3   = ld ? ref_load(3, sz, uns, a) : 32'h0;
    e_wb = mis ? 2'b00 : wb;
    $display("op rd=%0b wr=%0b sz=%0d uns=%0b addr=%h wdata=%h wreg=%0d wb=%0d exp0=%h exp3=%h",
             rd, wr, sz, uns, a, wd, wreg, wb, e0, e3);
    #1;
    chk("stall0_arrive", 32'(b0.stall), 32'h0);
    chk("stall3_arrive", 32'(b3.stall), 32'(acc));
    chk("pcsrc0", 32'(b0.PCSrc), 32'(mc & z));
    chk("pcsrc3", 32'(b3.PCSrc), 32'(mc & z));
    ns = 0;
    w0_done = 0;
    while (b3.stall === 1'b1 && ns < 12) begin
      ns++;
      @(negedge clk); #1;
      chk("pcsrc3_stall", 32'(b3.PCSrc), 32'(mc & z));
      if (!w0_done) begin
        check_outs(0, e0, a, wreg, e_wb, mis);
        w0_done = 1;
      end
    end
    @(negedge clk); #1;
    if (!w0_done) check_outs(0, e0, a, wreg, e_wb, mis);
    chk("stall3_cycles", 32'(ns), acc ? 32'd3 : 32'd0);
    check_outs(3, e3, a, wreg, e_wb, mis);
    if (wr && acc) begin
      ref_store(0, sz, a, wd);
      ref_store(3, sz, a, wd);
    end
  endtask

  task automatic check_zero_outs(input string tag);
    chk({tag, ".w0_rd"}, b0.read_data, 32'h0);
    chk({tag, ".w0_alu"}, b0.mem_ALU_result, 32'h0);
    chk({tag, ".w0_wb"}, 32'(b0.mem_control_wb), 32'h0);
    chk({tag, ".w0_reg"}, 32'(b0.mem_write_reg), 32'h0);
    chk({tag, ".w0_mis"}, 32'(b0.misalign), 32'h0);
    chk({tag, ".w3_rd"}, b3.read_data, 32'h0);
    chk({tag, ".w3_alu"}, b3.mem_ALU_result, 32'h0);
    chk({tag, ".w3_wb"}, 32'(b3.mem_control_wb), 32'h0);
    chk({tag, ".w3_reg"}, 32'(b3.mem_write_reg), 32'h0);
    chk({tag, ".w3_mis"}, 32'(b3.misalign), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 2'b10, 0, 32'h0, 32'h0, 5'd0, 2'b00, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    check_zero_outs("reset");
    rst_n = 1'b1;
    @(negedge clk); #1;

    for (int w = 0; w < 16; w++) op(0, 1, 2'b10, 0, 32'(w * 4), 32'h0, 5'd1, 2'b01, 0, 0);

    // misaligned word store must not write and must squash WB
    op(0, 1, 2'b10, 0, 32'h0A, 32'h00001100, 5'd3, 2'b11, 0, 0);
    chk("mis_flag", 32'(b0.misalign), 32'h1);
    op(1, 0, 2'b10, 0, 32'h08, 32'h0, 5'd4, 2'b11, 0, 0);
    chk("mis_nowrite", b0.read_data, 32'h0);
    op(0, 1, 2'b10, 0, 32'h08, 32'h00001100, 5'd5, 2'b10, 0, 0);
    op(1, 0, 2'b10, 0, 32'h08, 32'h0, 5'd6, 2'b11, 0, 0);
    chk("lw_08", b0.read_data, 32'h00001100);

    op(0, 1, 2'b10, 0, 32'h10, 32'h80F07F81, 5'd7, 2'b01, 0, 0);
    op(1, 0, 2'b00, 0, 32'h10, 32'h0, 5'd8, 2'b11, 0, 0);
    chk("lb_10", b3.read_data, 32'hFFFFFF81);
    op(1, 0, 2'b00, 1, 32'h13, 32'h0, 5'd9, 2'b11, 0, 0);
    chk("lbu_13", b3.read_data, 32'h00000080);
    op(1, 0, 2'b01, 0, 32'h12, 32'h0, 5'd10, 2'b11, 0, 0);
    chk("lh_12", b3.read_data, 32'hFFFF80F0);
    op(1, 0, 2'b01, 1, 32'h10, 32'h0, 5'd11, 2'b11, 0, 0);
    chk("lhu_10", b3.read_data, 32'h00007F81);
    op(0, 1, 2'b00, 0, 32'h11, 32'h000000AA, 5'd12, 2'b01, 0, 0);
    op(1, 0, 2'b10, 0, 32'h10, 32'h0, 5'd13, 2'b11, 0, 0);
    chk("lw_after_sb", b3.read_data, 32'h80F0AA81);

    // non-memory instruction right after a stalled load
    op(0, 0, 2'b10, 0, 32'h1234, 32'h0, 5'd17, 2'b11, 0, 0);

    op(0, 0, 2'b10, 0, 32'h40, 32'h0, 5'd2, 2'b10, 1, 0);
    op(1, 0, 2'b10, 0, 32'h08, 32'h0, 5'd2, 2'b10, 1, 1);
    op(0, 0, 2'b10, 0, 32'h44, 32'h0, 5'd2, 2'b10, 0, 1);

    op(0, 1, 2'b10, 0, 32'h400, 32'hDEADBEEF, 5'd14, 2'b01, 0, 0);
    op(1, 0, 2'b10, 0, 32'h000, 32'h0, 5'd15, 2'b11, 0, 0);
    chk("wrap_lw", b3.read_data, 32'hDEADBEEF);
    op(1, 1, 2'b10, 0, 32'h04, 32'hCAFEF00D, 5'd16, 2'b11, 0, 0);
    chk("rdwr_rd0", b3.read_data, 32'h0);
    op(1, 0, 2'b10, 0, 32'h04, 32'h0, 5'd18, 2'b11, 0, 0);
    chk("rdwr_stored", b3.read_data, 32'hCAFEF00D);

    // reset asserted during the second stall cycle of a pending store
    op(0, 1, 2'b10, 0, 32'h20, 32'h0, 5'd19, 2'b01, 0, 0);
    drive(0, 1, 2'b10, 0, 32'h20, 32'h12345678, 5'd20, 2'b01, 0, 0);
    $display("op reset-mid-wait sw addr=00000020 wdata=12345678");
    @(negedge clk); #1;
    chk("rst_wait_stall", 32'(b3.stall), 32'h1);
    ref_store(0, 2'b10, 32'h20, 32'h12345678);
    rst_n = 1'b0;
    #1;
    check_zero_outs("rst_mid");
    drive(0, 0, 2'b10, 0, 32'h0, 32'h0, 5'd0, 2'b00, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    op(1, 0, 2'b10, 0, 32'h20, 32'h0, 5'd21, 2'b11, 0, 0);
    chk("rst_store_dropped", b3.read_data, 32'h0);
    chk("w0_store_kept", b0.read_data, 32'h12345678);

    for (int k = 0; k < 80; k++) begin
      logic [31:0] a;
      a = ($urandom() & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
      op(1'($urandom()), 1'($urandom()), 2'($urandom()), 1'($urandom()), a, $urandom(),
         5'($urandom()), 2'($urandom()), 1'($urandom()), 1'($urandom()));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=done", total);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mem_stage_ext.md
Name: mem_stage_ext

Overview:
Parametrised successor to the MIPS pipeline MEM stage.
- Data memory supports byte, half and word accesses, with sign or zero extension on loads.
- Configurable memory wait states, with a stall handshake to upstream stages.
- Detects misaligned accesses and squashes the faulting write-back.
- Forms PCSrc and registers the MEM/WB pipeline latch: read data, ALU result, WB control, destination register.

Parameters:
- DATA_W, 32: data/word width in bits; must be 32.
- ADDR_W, 32: address width.
- DEPTH, 256: memory depth in words; power of two.
- REG_W, 5: register-number width.
- WB_W, 2: write-back control width.
- WAIT_STATES, 0: extra cycles per memory access; range 0..7.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- address  in  ADDR_W  byte address (ALU result from EX/MEM).
- write_data  in  DATA_W  store data, right-aligned.
- m_ctlout  in  1  branch control.
- zero  in  1  ALU zero flag.
- write_reg_in  in  REG_W  destination register.
- control_wb_in  in  WB_W  write-back control.
- memwrite  in  1  store request.
- memread  in  1  load request.
- mem_size  in  2  access size: 00 byte, 01 half, 10 word; 11 is treated as word.
- mem_unsigned  in  1  1 = zero-extend loads, 0 = sign-extend.
- read_data  out  DATA_W  registered load result.
- mem_ALU_result  out  DATA_W  registered copy of address.
- mem_control_wb  out  WB_W  registered WB control.
- mem_write_reg  out  REG_W  registered destination register.
- misalign  out  1  registered; 1 = the instruction now in MEM/WB faulted.
- PCSrc  out  1  combinational, m_ctlout & zero.
- stall  out  1  combinational; 1 = upstream must hold all inputs.

Behaviour:
- Reset (reset=0, asynchronous):
  - read_data, mem_ALU_result, mem_control_wb, mem_write_reg and misalign all go to 0.
  - FSM goes to IDLE; the wait counter goes to 0.
  - Memory contents are not reset.
- Word index is address[log2(DEPTH)+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH words.
- Alignment:
  - Half access is misaligned when address[0]=1.
  - Word access is misaligned when address[1:0]!=0.
  - Byte accesses are never misaligned.
- Access = (memread|memwrite) & !misaligned.
- memread and memwrite both high: treated as a store; read_data latched as 0.
- Store lanes:
  - Byte: write_data[7:0] into lane address[1:0].
  - Half: write_data[15:0] into lanes {address[1],0}.
  - Word: all four lanes.
  - Little-endian.
- Load: selected lane(s) extracted, then extended to 32 bits per mem_unsigned.
- Non-load or misaligned instruction: read_data latched as 0.
- Misaligned instruction:
  - No memory write.
  - No wait states.
  - misalign latched as 1.
  - mem_control_wb latched as 0 (squash).
  - mem_ALU_result and mem_write_reg latched normally.
- FSM:
  - IDLE → WAIT when an access arrives and WAIT_STATES>0. Counter loads WAIT_STATES-1. stall=1 combinationally in this arrival cycle.
  - WAIT: stall=1. Counter decrements each cycle. At counter==0, go to DONE.
  - DONE: stall=0. Store commits on this edge, load data and the MEM/WB latch update on this edge, then return to IDLE.
- WAIT_STATES=0: the FSM never leaves IDLE. Store commits and the MEM/WB latch loads on the first edge; this is 1-cycle latency.
- Timing with WAIT_STATES=W: stall is high for exactly W cycles, and outputs update at the W+1th edge after arrival.
- The MEM/WB latch loads only on edges where stall=0.
- While stall=1, upstream inputs are required stable; inputs changing during stall are ignored except on the completing edge.
- Non-memory instructions never stall and pass through in 1 cycle.
- PCSrc is purely combinational and independent of stall and FSM state.
- Back-to-back: a load issued immediately after a store to the same word returns the new data.
- Reset asserted mid-WAIT: pending store is discarded; FSM returns to IDLE; outputs cleared.

Decomposition:
- Package mem_stage_pkg:
  - Size constants: SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - FSM state encodings: IDLE, WAIT, DONE.
  - Alignment-check function.
  - Load extract/extend function.
- Sub-module dmem_byte_ram:
  - DEPTH x 32 words.
  - 4-bit byte-enable synchronous write.
  - Combinational read.
  - No reset.

Test Plan:
- WAIT_STATES=0, word store then load:
  - Store: addr 0x0A with write_data 0x00001100, mem_size=10.
  - Required: misalign=1 after 1 edge, no write, mem_control_wb=00.
  - Then at addr 0x08: store 0x00001100, then load → read_data=0x00001100 one edge after load issue.
- Byte/half extension:
  - Store word 0x80F07F81 at 0x10.
  - lb signed @0x10 → 0xFFFFFF81.
  - lbu @0x13 → 0x00000080.
  - lh @0x12 → 0xFFFF80F0.
  - lhu @0x10 → 0x00007F81.
  - sb 0xAA @0x11, then lw @0x10 → 0x80F0AA81.
- WAIT_STATES=3, lw @0x08:
  - stall high for exactly 3 cycles.
  - MEM/WB updates on the 4th edge.
  - Non-memory instruction following it → no stall, 1-cycle pass-through with control_wb/write_reg intact.
- PCSrc:
  - m_ctlout=1, zero=0 → 0.
  - zero=1 → 1 in the same cycle, including while stall=1.
  - m_ctlout=0 → 0.
- Reset mid-WAIT, WAIT_STATES=3:
  - Issue sw 0x12345678 @0x20; drive reset=0 during the 2nd stall cycle; release; then lw @0x20.
  - Required: the loaded value is the pre-store value (0 after a prior sw 0 @0x20), not 0x12345678.
  - Required: all outputs 0 during reset.
- Wrap and simultaneous request, DEPTH=256:
  - sw 0xDEADBEEF @0x400 → lw @0x000 returns 0xDEADBEEF.
  - memread=memwrite=1 → treated as a store; read_data=0.
